// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall / flush / halt controller.
//
// Merges per-stage stall requests, fixed-length multi-cycle stalls, flush/redirect
// requests and a debug halt into one per-stage stall vector plus a registered
// flush pulse carrying the redirect PC.
//
// Stall vector: bit 0 = PC, bit 1 = IF/ID, ... bit STAGES-1 = last pipeline
// register. A set bit holds that stage. Holding stage k always holds every
// stage before it, so all masks are contiguous from bit 0.
//
// Ports:
//   clk_i        system clock, all state on the rising edge
//   rst_ni       synchronous active-low reset
//   stallreq_i   per-stage stall request, bit i = stage i cannot advance
//   mc_start_i   single-cycle pulse starting a multi-cycle stall
//   mc_stage_i   highest stage held during the multi-cycle stall
//   mc_cycles_i  multi-cycle stall length in cycles (0 = no stall)
//   flush_req_i  flush the pipeline and redirect to flush_pc_i
//   flush_pc_i   redirect target, sampled with flush_req_i
//   halt_req_i   enter debug halt
//   resume_i     leave debug halt
//   stall_o      per-stage stall vector (combinational)
//   flush_o      registered flush pulse
//   new_pc_o     registered redirect PC, valid while flush_o is high
//   mc_busy_o    multi-cycle stall in progress

module pipe_stall_ctrl #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned IDX_W  = $clog2(STAGES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              mc_start_i,
  input  logic [IDX_W-1:0]  mc_stage_i,
  input  logic [CNT_W-1:0]  mc_cycles_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              halt_req_i,
  input  logic              resume_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              mc_busy_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(STAGES - 1);

  typedef enum logic [1:0] {
    StRun,
    StMc,
    StFlush,
    StHalt
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    mc_stage_q, mc_stage_d;
  logic                flush_q, flush_d;
  logic [ADDR_W-1:0]   new_pc_q, new_pc_d;

  logic [STAGES-1:0]   req_mask;
  logic [STAGES-1:0]   state_mask;
  logic [IDX_W-1:0]    mc_stage_sat;
  logic                mc_go;

  // Bits 0..idx set, all others clear.
  function automatic logic [STAGES-1:0] upto_mask(input logic [IDX_W-1:0] idx);
    logic [STAGES-1:0] m;
    for (int k = 0; k < STAGES; k++) begin
      m[k] = (k <= int'(idx));
    end
    return m;
  endfunction

  // Request mask: a stage is held if it or any later stage requests a stall,
  // which equals the mask up to the highest set request bit.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc         = acc | stallreq_i[k];
      req_mask[k] = acc;
    end
  end

  // Out-of-range stage indices hold the whole pipe.
  assign mc_stage_sat = (mc_stage_i > LastIdx) ? LastIdx : mc_stage_i;

  // A multi-cycle stall only starts from RUN and loses to flush and halt.
  assign mc_go = (state_q == StRun) && mc_start_i && (mc_cycles_i != '0) &&
                 !flush_req_i && !halt_req_i;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mc_stage_d = mc_stage_q;
    flush_d    = 1'b0;
    new_pc_d   = new_pc_q;

    if (flush_req_i) begin
      // Flush wins over everything but reset, from any state.
      state_d  = StFlush;
      flush_d  = 1'b1;
      new_pc_d = flush_pc_i;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req_i) begin
            state_d = StHalt;
            cnt_d   = '0;
          end else if (mc_go) begin
            mc_stage_d = mc_stage_sat;
            cnt_d      = mc_cycles_i - CNT_W'(1);
            // A one-cycle stall is fully covered by the start cycle itself.
            if (mc_cycles_i != CNT_W'(1)) begin
              state_d = StMc;
            end
          end
        end
        StMc: begin
          if (halt_req_i) begin
            state_d = StHalt;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_d = StRun;
            end
          end
        end
        StFlush: begin
          state_d = StRun;
        end
        StHalt: begin
          // resume beats a simultaneous halt_req.
          if (resume_i) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // Stall contribution of the current state.
  always_comb begin
    state_mask = '0;
    unique case (state_q)
      StRun:   state_mask = mc_go ? upto_mask(mc_stage_sat) : '0;
      StMc:    state_mask = upto_mask(mc_stage_q);
      StHalt:  state_mask = '1;
      StFlush: state_mask = '0;
      default: state_mask = '0;
    endcase
  end

  // During the flush cycle the pipe must advance to drain, so requests are ignored.
  assign stall_o   = (state_q == StFlush) ? '0 : (req_mask | state_mask);
  assign mc_busy_o = (state_q == StMc);
  assign flush_o   = flush_q;
  assign new_pc_o  = new_pc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      mc_stage_q <= '0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mc_stage_q <= mc_stage_d;
      flush_q    <= flush_d;
      new_pc_q   <= new_pc_d;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl (STAGES=6, ADDR_W=32, CNT_W=4): a directed
// cycle table followed by random stimulus compared against a reference model.

module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stallreq;
  logic        mc_start;
  logic [2:0]  mc_stage;
  logic [3:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        halt_req;
  logic        resume;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stall_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .stallreq_i  (stallreq),
    .mc_start_i  (mc_start),
    .mc_stage_i  (mc_stage),
    .mc_cycles_i (mc_cycles),
    .flush_req_i (flush_req),
    .flush_pc_i  (flush_pc),
    .halt_req_i  (halt_req),
    .resume_i    (resume),
    .stall_o     (stall),
    .flush_o     (flush),
    .new_pc_o    (new_pc),
    .mc_busy_o   (mc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  req;
    logic        go;
    logic [2:0]  stg;
    logic [3:0]  cyc;
    logic        fl;
    logic [31:0] pc;
    logic        halt;
    logic        res;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t tq[$];

  function automatic vec_t v(logic rst, logic [5:0] req, logic go, logic [2:0] stg,
                             logic [3:0] cyc, logic fl, logic [31:0] pc, logic halt,
                             logic res, logic [5:0] e_stall, logic e_flush,
                             logic [31:0] e_pc, logic e_busy);
    vec_t r;
    r.rst = rst; r.req = req; r.go = go; r.stg = stg; r.cyc = cyc; r.fl = fl;
    r.pc = pc; r.halt = halt; r.res = res; r.e_stall = e_stall; r.e_flush = e_flush;
    r.e_pc = e_pc; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [5:0] req, input logic go,
                       input logic [2:0] stg, input logic [3:0] cyc, input logic fl,
                       input logic [31:0] pc, input logic halt, input logic res);
    rst_n = rst; stallreq = req; mc_start = go; mc_stage = stg; mc_cycles = cyc;
    flush_req = fl; flush_pc = pc; halt_req = halt; resume = res;
  endtask

  // Reference model: remaining held cycles, halt/flush flags, last redirect PC.
  int          m_left;
  int          m_top;
  bit          m_halt;
  bit          m_flush;
  logic [31:0] m_pc;

  function automatic int upto(int i);
    return (1 << (i + 1)) - 1;
  endfunction

  function automatic int req_mask(logic [5:0] r);
    int h = -1;
    for (int i = 0; i < 6; i++) if (r[i]) h = i;
    return (h < 0) ? 0 : upto(h);
  endfunction

  function automatic int sat(logic [2:0] s);
    return (int'(s) > 5) ? 5 : int'(s);
  endfunction

  function automatic int model_stall();
    int e;
    if (m_flush) return 0;
    if (m_halt) return 63;
    e = req_mask(stallreq);
    if (m_left > 0) e = e | upto(m_top);
    else if (mc_start && mc_cycles != 0 && !flush_req && !halt_req) e = e | upto(sat(mc_stage));
    return e;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_left = 0; m_top = 0; m_halt = 0; m_flush = 0; m_pc = '0;
    end else if (flush_req) begin
      m_flush = 1; m_pc = flush_pc; m_left = 0; m_halt = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (halt_req) begin
      m_halt = 1; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (mc_start && mc_cycles != 0) begin
      m_left = int'(mc_cycles) - 1;
      m_top  = sat(mc_stage);
    end
  endtask

  initial begin
    // rst req go stg cyc fl pc halt res | stall flush new_pc busy
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000100, 0, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0));
    tq.push_back(v(1, 6'b000010, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b100000, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 1, 3, 5, 0, 0, 0, 0, 6'b001111, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b000000, 1, 1, 2, 0, 0, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 1, 3, 5, 0, 0, 0, 0, 6'b001111, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b000001, 0, 0, 0, 1, 32'h100, 0, 0, 6'b001111, 0, 0, 1));
    tq.push_back(v(1, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h100, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h100, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 1, 32'h200, 0, 0, 6'b000000, 0, 32'h100, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 1, 32'h300, 0, 0, 6'b000000, 1, 32'h200, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h300, 0));
    tq.push_back(v(1, 6'b000100, 0, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 1, 1, 6'b111111, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 1, 32'h400, 0, 0, 6'b111111, 0, 32'h300, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 1, 5, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 1, 2, 1, 0, 0, 0, 0, 6'b000111, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 1, 7, 3, 0, 0, 0, 0, 6'b111111, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 32'h400, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 32'h400, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 1, 2, 4, 0, 0, 0, 0, 6'b000111, 0, 32'h400, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 32'h400, 1));
    tq.push_back(v(0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000111, 0, 32'h400, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 1, 1, 3, 0, 0, 1, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 6'b111111, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 1, 4, 3, 1, 32'h500, 0, 0, 6'b000000, 0, 0, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 32'h500, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h500, 0));
    tq.push_back(v(1, 6'b000000, 1, 1, 6, 0, 0, 0, 0, 6'b000011, 0, 32'h500, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 1, 0, 6'b000011, 0, 32'h500, 1));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 32'h500, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 1, 6'b111111, 0, 32'h500, 0));
    tq.push_back(v(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 32'h500, 0));

    // Reset for two edges, then one table row per cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    foreach (tq[i]) begin
      drive(tq[i].rst, tq[i].req, tq[i].go, tq[i].stg, tq[i].cyc, tq[i].fl, tq[i].pc,
            tq[i].halt, tq[i].res);
      #3;
      check($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tq[i].e_stall));
      check($sformatf("tbl%0d.flush", i), 32'(flush), 32'(tq[i].e_flush));
      check($sformatf("tbl%0d.new_pc", i), new_pc, tq[i].e_pc);
      check($sformatf("tbl%0d.mc_busy", i), 32'(mc_busy), 32'(tq[i].e_busy));
      @(posedge clk);
      #1;
    end

    // Random phase against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    m_left = 0; m_top = 0; m_halt = 0; m_flush = 0; m_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(99) != 0),
            ($urandom_range(3) == 0) ? 6'($urandom) : 6'b0,
            ($urandom_range(5) == 0),
            3'($urandom),
            4'($urandom),
            ($urandom_range(19) == 0),
            $urandom,
            ($urandom_range(29) == 0),
            ($urandom_range(4) == 0));
      #3;
      check("rnd.stall", 32'(stall), 32'(model_stall()));
      check("rnd.flush", 32'(flush), 32'(m_flush));
      check("rnd.new_pc", new_pc, m_pc);
      check("rnd.mc_busy", 32'(mc_busy), 32'(m_left > 0));
      model_edge();
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Parametrised pipeline control unit; successor to the fixed 6-stage stall controller.
- Merges per-stage stall requests, fixed-latency multi-cycle stalls (divider, memory wait), flush/redirect requests and a debug halt.
- Drives a per-stage stall vector plus a registered flush pulse with redirect PC to all pipeline registers and the PC unit.
- Stall vector encoding is unchanged: bit 0 = PC, bit 1 = IF/ID, ... bit STAGES-1 = last pipeline register; bit k=1 holds stage k.

Parameters:
- STAGES, 6, stall vector width / number of pipeline registers including PC.
- ADDR_W, 32, width of redirect PC.
- CNT_W, 4, width of multi-cycle stall length counter.
- IDX_W, $clog2(STAGES), width of stage index fields.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-low reset.
- stallreq  in  STAGES  per-stage stall request; bit i=1 means stage i cannot advance.
- mc_start  in  1  start multi-cycle stall (single-cycle pulse).
- mc_stage  in  IDX_W  highest stage held during the multi-cycle stall.
- mc_cycles  in  CNT_W  multi-cycle stall length in cycles.
- flush_req  in  1  flush pipeline and redirect (branch mispredict / exception).
- flush_pc  in  ADDR_W  redirect target, sampled with flush_req.
- halt_req  in  1  enter halt (debug).
- resume  in  1  leave halt.
- stall  out  STAGES  per-stage stall vector.
- flush  out  1  registered flush pulse.
- new_pc  out  ADDR_W  registered redirect PC, valid while flush=1.
- mc_busy  out  1  multi-cycle stall in progress.

Behaviour:
- Reset (rst=0 at clk edge):
  - State = RUN; stall=0, flush=0, new_pc=0, mc_busy=0, counter=0.
  - Reset mid-multi-cycle or mid-halt aborts immediately.
- Mask function mask(i): bits 0..i set, all others clear. Example: STAGES=6, i=2 gives 6'b000111.
- Request mask: mask(h), where h is the highest set bit of stallreq; 0 if stallreq=0. Combinational, same cycle.
- States: RUN, MC, FLUSH, HALT.
- RUN:
  - stall = request mask.
  - mc_start with mc_cycles=N>=1: stall = request mask OR mask(mc_stage) this cycle; latch mc_stage; counter=N-1.
    - N>1: go to MC.
    - N=1: stay in RUN; single stalled cycle.
  - mc_start with N=0: ignored.
  - mc_stage >= STAGES: saturate to STAGES-1.
- MC:
  - mc_busy=1; stall = request mask OR mask(latched stage).
  - Counter decrements each cycle; state returns to RUN when the counter reaches 0.
  - Total held cycles = N, counting the mc_start cycle.
  - mc_start while busy: ignored.
- Flush (any state, highest priority):
  - flush_req at cycle t: flush=1 and new_pc=flush_pc at t+1; state FLUSH for one cycle.
  - Counter cleared, mc_busy=0, pending mc_start in cycle t dropped.
  - In the FLUSH cycle, stall forced to 0 regardless of stallreq.
  - Back-to-back flush_req: flush stays 1; new_pc takes the latest flush_pc each cycle.
  - Otherwise FLUSH moves to RUN; flush returns to 0.
  - new_pc holds its last value when flush=0.
- Halt:
  - halt_req in RUN or MC (no flush_req): HALT from the next cycle; multi-cycle stall aborted; stall = all ones.
  - HALT + resume: RUN next cycle.
  - HALT + flush_req: FLUSH (flush wins).
  - halt_req and resume together in HALT: resume wins.
  - halt_req in the cycle of flush_req: ignored.
- Priority: rst > flush_req > halt_req/resume > mc_start > stallreq.
- All outputs except stall and mc_busy are registered; stall is the combinational OR of the request mask and the registered state mask.

Test Plan (STAGES=6, CNT_W=4):
- Reset, then stallreq=6'b000100 for 1 cycle -> stall=6'b000111 same cycle; stallreq=6'b000010 -> stall=6'b000011; stallreq=0 -> stall=0; flush=0, new_pc=0 throughout.
- mc_start, mc_stage=3, mc_cycles=5 at cycle 10 -> stall=6'b001111 on cycles 10..14; mc_busy=1 on 11..14; stall=0 at cycle 15. Second mc_start at cycle 12 is ignored.
- flush_req=1, flush_pc=32'h0000_0100 at cycle 12 during an MC stall -> cycle 13: flush=1, new_pc=32'h100, stall=0 (even with stallreq=6'b111111), mc_busy=0; cycle 14: flush=0, state RUN.
- flush_req on cycles 20,21 with flush_pc 32'h200 then 32'h300 -> flush=1 on 21,22; new_pc=32'h200 then 32'h300; flush=0 at 23.
- halt_req at cycle 30 -> stall=6'b111111 from 31 until resume at 40; stall=0 at 41. Repeat with flush_req at cycle 35 -> flush=1 at 36, RUN at 37.
- mc_cycles=0 -> no stall; mc_cycles=1 -> single-cycle stall, mc_busy never 1. rst=0 asserted mid-MC -> all outputs 0 at the next edge.
